// File: rtl/spi_slave_stream.sv
// spi_slave_stream: full-duplex SPI slave, oversampled in the clk domain.
// Received words leave as single-cycle pulses. Outgoing words come from a
// one-word buffer that fabric fills through a valid/ready handshake.
module spi_slave_stream #(
  parameter int DATA_W = 8,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              sck_meta_r, sck_sync_r, sck_prev_r;
  logic              mosi_meta_r, mosi_sync_r;
  logic              cs_meta_r, cs_act_r, cs_act_prev_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic [DATA_W-1:0] buf_r;
  logic              full_r;
  logic [DATA_W-1:0] tx_word_r;
  logic              miso_r;
  logic              underrun_r;

  logic              rise_s, fall_s, lead_s, trail_s;
  logic              sample_s, shift_s, load_s, write_s, cs_rise_s;
  logic [DATA_W-1:0] rx_next_s;
  logic [DATA_W-1:0] tx_shl_s;

  // Two-stage synchronisers for all pins, plus an edge-history stage on SCK.
  // Idle levels are the reset values so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_r    <= CPOL;
      sck_sync_r    <= CPOL;
      sck_prev_r    <= CPOL;
      mosi_meta_r   <= 1'b0;
      mosi_sync_r   <= 1'b0;
      cs_meta_r     <= 1'b1;
      cs_act_r      <= 1'b0;
      cs_act_prev_r <= 1'b0;
    end else begin
      sck_meta_r    <= spi_sck;
      sck_sync_r    <= sck_meta_r;
      sck_prev_r    <= sck_sync_r;
      mosi_meta_r   <= spi_mosi;
      mosi_sync_r   <= mosi_meta_r;
      cs_meta_r     <= spi_cs;
      cs_act_r      <= ~cs_meta_r;
      cs_act_prev_r <= cs_act_r;
    end
  end

  assign rise_s    = sck_sync_r & ~sck_prev_r & cs_act_r;
  assign fall_s    = ~sck_sync_r & sck_prev_r & cs_act_r;
  assign cs_rise_s = cs_act_r & ~cs_act_prev_r;
  assign write_s   = tx_valid & ~full_r;
  assign rx_next_s = {rx_shift_r[DATA_W-2:0], mosi_sync_r};
  assign tx_shl_s  = tx_word_r << cnt_r;

  // Map raw SCK edges onto sample/shift strobes for the selected mode and
  // decide when the next transmit word is taken from the buffer.
  always_comb begin
    lead_s   = rise_s;
    trail_s  = fall_s;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    load_s   = 1'b0;
    if (CPOL) begin
      lead_s  = fall_s;
      trail_s = rise_s;
    end else begin
      lead_s  = rise_s;
      trail_s = fall_s;
    end
    if (CPHA) begin
      sample_s = trail_s;
      shift_s  = lead_s;
      load_s   = lead_s && (cnt_r == '0);
    end else begin
      sample_s = lead_s;
      shift_s  = trail_s;
      load_s   = cs_rise_s || (trail_s && (cnt_r == '0));
    end
  end

  // Receive shifter and bit counter; a deselect discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (!cs_act_r) begin
        cnt_r      <= '0;
        rx_shift_r <= '0;
      end else if (sample_s) begin
        rx_shift_r <= rx_next_s;
        if (cnt_r == CNT_LAST) begin
          cnt_r      <= '0;
          rx_data_r  <= rx_next_s;
          rx_valid_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // One-word TX buffer. A write in the same cycle as a load wins the flag,
  // because a write only happens when the buffer is empty and the load
  // therefore already underran.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r  <= '0;
      full_r <= 1'b0;
    end else if (write_s) begin
      buf_r  <= tx_data;
      full_r <= 1'b1;
    end else if (load_s) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  // Transmit word register and registered MISO; zero while deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word_r  <= '0;
      miso_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (!cs_act_r) begin
        tx_word_r <= '0;
        miso_r    <= 1'b0;
      end else if (load_s) begin
        if (full_r) begin
          tx_word_r <= buf_r;
          miso_r    <= buf_r[DATA_W-1];
        end else begin
          tx_word_r  <= '0;
          miso_r     <= 1'b0;
          underrun_r <= 1'b1;
        end
      end else if (shift_s) begin
        miso_r <= tx_shl_s[DATA_W-1];
      end else begin
        miso_r <= miso_r;
      end
    end
  end

  assign spi_miso    = miso_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_ready    = ~full_r;
  assign tx_underrun = underrun_r;
  assign busy        = cs_act_r;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: four 8-bit instances (modes 0..3) and one
// 16-bit mode-0 instance share SCK/MOSI, each with its own chip select.
module tb_spi_slave_stream;

  localparam int NI = 5;
  localparam int H  = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck_base = 1'b0;
  logic          mosi = 1'b0;
  logic [NI-1:0] cs_n = '1;
  logic [NI-1:0] tx_valid = '0;
  logic [15:0]   tx_data_v = '0;
  logic [NI-1:0] miso_a, rx_valid_a, tx_ready_a, underrun_a, busy_a;
  logic [15:0]   rx_data_a [NI];

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int urun_cnt = 0;
  int exp_ur = 0;
  int stray = 0;
  logic [15:0] rxq [$];
  longint      rxt [$];
  logic        mfull [NI];
  logic [15:0] mbuf [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = (g == 4) ? 16 : 8;
    localparam bit PO = (g == 2) || (g == 3);
    localparam bit PH = (g == 1) || (g == 3);
    logic [DW-1:0] rxd;
    spi_slave_stream #(.DATA_W(DW), .CPOL(PO), .CPHA(PH)) u_dut (
      .clk(clk), .rst_n(rst_n), .spi_sck(sck_base ^ PO), .spi_mosi(mosi),
      .spi_cs(cs_n[g]), .spi_miso(miso_a[g]), .rx_data(rxd),
      .rx_valid(rx_valid_a[g]), .tx_data(tx_data_v[DW-1:0]),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready_a[g]),
      .tx_underrun(underrun_a[g]), .busy(busy_a[g]));
    assign rx_data_a[g] = 16'(rxd);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor for the selected instance; pulses elsewhere are strays.
  always @(negedge clk) begin
    if (rx_valid_a[cur]) begin
      rxq.push_back(rx_data_a[cur]);
      rxt.push_back($time);
    end
    if (underrun_a[cur]) urun_cnt++;
    for (int k = 0; k < NI; k++)
      if (k != cur && (rx_valid_a[k] || underrun_a[k])) stray++;
  end

  // Reference: a load takes the buffered word if present, else sends zero.
  task automatic model_load(input int i, output logic [15:0] w);
    if (mfull[i]) begin
      w = mbuf[i];
      mfull[i] = 1'b0;
    end else begin
      w = 16'h0000;
      exp_ur++;
    end
  endtask

  task automatic fabric_write(input int i, input logic [15:0] d);
    check("tx_ready_pre", tx_ready_a[i], !mfull[i]);
    if (!mfull[i]) begin
      tx_data_v = d;
      tx_valid[i] = 1'b1;
      #10;
      tx_valid[i] = 1'b0;
      mfull[i] = 1'b1;
      mbuf[i] = (i == 4) ? d : (d & 16'h00FF);
    end else begin
      #10;
    end
  endtask

  task automatic half_wait(input int i, input bit wr, input logic [15:0] d);
    if (wr) begin
      fabric_write(i, d);
      #(H - 10);
    end else begin
      #H;
    end
  endtask

  task automatic run_frame(input int i, input int nw, input int abort_bits,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input bit refill, input logic [15:0] rdata);
    int dw, nb, exp_rx;
    bit cpha;
    logic [15:0] m, got, dummy;
    logic [15:0] words [2];
    logic [15:0] exp_w [2];
    dw = (i == 4) ? 16 : 8;
    cpha = (i == 1) || (i == 3);
    m = (dw == 16) ? 16'hFFFF : 16'h00FF;
    words[0] = w0 & m;
    words[1] = w1 & m;
    exp_w[0] = 16'h0;
    exp_w[1] = 16'h0;
    rxq.delete();
    rxt.delete();
    urun_cnt = 0;
    exp_ur = 0;
    cur = i;
    nb = dw;
    @(posedge clk);
    #3;
    cs_n[i] = 1'b0;
    #60;
    check("busy_active", busy_a[i], 1'b1);
    for (int w = 0; w < nw; w++) begin
      model_load(i, exp_w[w]);
      got = 16'h0;
      nb = (abort_bits > 0) ? abort_bits : dw;
      for (int b = 0; b < nb; b++) begin
        if (!cpha) begin
          mosi = words[w][dw-1-b];
          half_wait(i, refill && (w == 0) && (b == dw / 2), rdata);
          sck_base = 1'b1;
          got = {got[14:0], miso_a[i]};
          #H;
          sck_base = 1'b0;
        end else begin
          sck_base = 1'b1;
          mosi = words[w][dw-1-b];
          half_wait(i, refill && (w == 0) && (b == dw / 2), rdata);
          sck_base = 1'b0;
          got = {got[14:0], miso_a[i]};
          #H;
        end
      end
      if (nb == dw) check("miso_word", got & m, exp_w[w]);
    end
    if (!cpha && nb == dw) model_load(i, dummy);
    #80;
    cs_n[i] = 1'b1;
    #100;
    exp_rx = (abort_bits > 0) ? 0 : nw;
    check("busy_idle", busy_a[i], 1'b0);
    check("miso_idle", miso_a[i], 1'b0);
    check("rx_count", rxq.size(), exp_rx);
    for (int k = 0; k < exp_rx; k++)
      check("rx_word", (k < rxq.size()) ? 32'(rxq[k]) : 32'hDEADBEEF, words[k]);
    check("underrun_count", urun_cnt, exp_ur);
    check("tx_ready", tx_ready_a[i], !mfull[i]);
    if (exp_rx == 2 && rxt.size() == 2)
      check("rx_spacing", 32'(rxt[1] - rxt[0]), dw * 2 * H);
  endtask

  initial begin
    logic [15:0] r0, r1;
    int ri, nw, ab;
    for (int k = 0; k < NI; k++) begin
      mfull[k] = 1'b0;
      mbuf[k] = 16'h0;
    end
    #23;
    for (int k = 0; k < NI; k++) begin
      check("rst_miso", miso_a[k], 1'b0);
      check("rst_rx_data", rx_data_a[k], 16'h0);
      check("rst_rx_valid", rx_valid_a[k], 1'b0);
      check("rst_tx_ready", tx_ready_a[k], 1'b1);
      check("rst_underrun", underrun_a[k], 1'b0);
      check("rst_busy", busy_a[k], 1'b0);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #50;

    // Mode 0, 8 bit.
    fabric_write(0, 16'h003C);
    run_frame(0, 1, 0, 16'h00A5, 16'h0, 1'b0, 16'h0);
    // Modes 1..3.
    for (int md = 1; md < 4; md++) begin
      fabric_write(md, 16'h00C3);
      run_frame(md, 1, 0, 16'h005A, 16'h0, 1'b0, 16'h0);
    end
    // 16 bit back-to-back with mid-word refill.
    fabric_write(4, 16'hCAFE);
    run_frame(4, 2, 0, 16'h1234, 16'hBEEF, 1'b1, 16'h0F0F);
    // Empty buffer at select (single load in CPHA=1).
    run_frame(1, 1, 0, 16'h0096, 16'h0, 1'b0, 16'h0);
    // Abort after 5 bits, then a full 0x81 frame.
    run_frame(0, 1, 5, 16'h00FF, 16'h0, 1'b0, 16'h0);
    run_frame(0, 1, 0, 16'h0081, 16'h0, 1'b0, 16'h0);

    // Reset at bit 3 of a mode-0 frame with the buffer full.
    fabric_write(0, 16'h0077);
    cur = 0;
    cs_n[0] = 1'b0;
    #60;
    for (int b = 0; b < 3; b++) begin
      mosi = b[0];
      #H;
      sck_base = 1'b1;
      #H;
      sck_base = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", miso_a[0], 1'b0);
    check("mid_rst_rx_data", rx_data_a[0], 16'h0081 & 16'h0);
    check("mid_rst_rx_valid", rx_valid_a[0], 1'b0);
    check("mid_rst_tx_ready", tx_ready_a[0], 1'b1);
    check("mid_rst_underrun", underrun_a[0], 1'b0);
    check("mid_rst_busy", busy_a[0], 1'b0);
    cs_n[0] = 1'b1;
    for (int k = 0; k < NI; k++) mfull[k] = 1'b0;
    #49;
    rst_n = 1'b1;
    #50;
    fabric_write(0, 16'h00E7);
    run_frame(0, 1, 0, 16'h0042, 16'h0, 1'b0, 16'h0);

    // Randomised frames across all instances.
    for (int n = 0; n < 20; n++) begin
      ri = $urandom_range(0, NI - 1);
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      nw = (ri == 4) ? $urandom_range(1, 2) : 1;
      ab = 0;
      if (nw == 1 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, (ri == 4) ? 15 : 7);
      if ($urandom_range(0, 1) == 1) fabric_write(ri, 16'($urandom));
      run_frame(ri, nw, ab, r0, r1, nw == 2 && $urandom_range(0, 1) == 1, 16'($urandom));
    end

    check("stray_pulses", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_stream.md
# spi_slave_stream

Parametrised, full-duplex SPI slave. It replaces the fixed 8-bit receive-only slave with configurable word width, all four CPOL/CPHA modes, a transmit path with a one-word buffer, and error flags. All SPI pins are oversampled in the single system clock domain. Received words are streamed to fabric logic as one-cycle pulses; fabric supplies outgoing words through a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 8: bits per SPI word, ≥ 2; words are MSB first.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on the leading edge, shift on the trailing edge; 1 = shift on the leading edge, sample on the trailing edge.

Ports:
- clk  in  1  system clock; f_sck ≤ f_clk/8.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock, asynchronous to clk.
- spi_mosi  in  1  master-out data.
- spi_cs  in  1  chip select, active low.
- spi_miso  out  1  slave-out data; 0 when spi_cs is high.
- rx_data  out  DATA_W  last complete received word; holds until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  the TX buffer is empty.
- tx_underrun  out  1  one-cycle pulse when a word load finds the TX buffer empty.
- busy  out  1  synchronised chip select is active.

## Operation
- **Synchronisers:** spi_sck, spi_mosi and spi_cs each pass through a 2-FF synchroniser. A third register on SCK produces the rise and fall strobes.
- **Edge mapping:**
  - Leading edge = rise if CPOL = 0, fall if CPOL = 1.
  - sample_edge = leading edge if CPHA = 0, else trailing edge.
  - shift_edge = the other edge.
  - Both strobes are gated by the synchronised chip select being low.
- **Bit counter:** cnt runs 0..DATA_W-1 and advances on sample_edge.
- **Receive:** on each sample_edge, rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}. When cnt = DATA_W-1:
  - rx_data <= the full word, including the bit just sampled;
  - rx_valid pulses on the next cycle;
  - cnt wraps to 0.
- **TX buffer:** one register plus a full flag.
  - tx_ready = ~full.
  - A write happens when tx_valid && tx_ready; full is set on the next cycle.
- **Word load:** tx_word <= buffer and full is cleared. If the buffer is empty, tx_word <= 0 and tx_underrun pulses. A load occurs:
  - CPHA = 0: when chip select asserts, and on every shift_edge with cnt = 0 (start of the next word).
  - CPHA = 1: on every shift_edge with cnt = 0.
- **MISO drive:** spi_miso is registered.
  - At a load: spi_miso <= the loaded word's MSB.
  - On other shift_edges: spi_miso <= tx_word[DATA_W-1-cnt].
  - When chip select is deasserted: spi_miso <= 0.
- **Chip select deasserted mid-word:**
  - cnt <= 0 and the partial rx_shift is discarded; no rx_valid.
  - The TX buffer contents are retained.
  - The current tx_word is dropped.
- **Same-cycle load and write:** the load sees the pre-write buffer state. If the buffer was empty, the load underruns and the written word is kept for the following word.

## Timing
- **Reset values:** spi_miso 0, rx_data 0, rx_valid 0, tx_ready 1, tx_underrun 0, busy 0, cnt 0, buffer empty.
- **SCK edge to strobe:** 3 clk (2 sync stages plus the edge register). MOSI and CS use the same sync depth, so data and chip select stay aligned with SCK.
- **Receive latency:** rx_valid is high in the cycle after the final sample strobe, i.e. 4 clk after that pin edge (±1 for synchroniser phase).
- **Chip select to first MISO bit:** for CPHA = 0, spi_miso shows the MSB 3 clk after spi_cs falls. For CPHA = 1, it shows the MSB 3 clk after the first leading edge.
- **Back-to-back words:** continuous SCK with no gap is supported. Fabric has DATA_W SCK periods to refill the buffer before the next load.
- **Busy:** rises and falls 2 clk after spi_cs changes.

## Test plan
- **Mode 0, DATA_W = 8:** master sends 0xA5 while the buffer holds 0x3C -> rx_data = 0xA5 with one rx_valid pulse; master reads 0x3C; tx_ready rises at the load.
- **Modes 1, 2, 3:** master sends 0x5A and the slave sends 0xC3 in each mode -> both sides receive correctly; no pulse on unused edges.
- **DATA_W = 16, two back-to-back words:** 0x1234 then 0xBEEF, with tx refilled from 0xCAFE to 0x0F0F between words -> two rx_valid pulses 16 SCK periods apart; MISO shows 0xCAFE then 0x0F0F.
- **Empty TX buffer at chip select:** -> tx_underrun pulses once; MISO sends 0x00; receive is unaffected.
- **Chip select deasserted after 5 bits, then a full frame of 0x81:** -> no rx_valid for the aborted frame; next rx_data = 0x81.
- **Reset mid-frame:** assert rst_n low at bit 3 -> all outputs return to reset values immediately; after release, the next full frame receives correctly.
